// File: rtl/write_queue.sv
// Buffered write-request FIFO feeding the 3-to-8 write-enable decoder and register file.
// It drains one {Addr, wr_data} write per cycle unless held, flushed or in reset.
module write_queue #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 3,
  parameter int DEPTH      = 4
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        s_valid,
  output logic                        s_ready,
  input  logic [ADDR_WIDTH-1:0]       s_addr,
  input  logic [DATA_WIDTH-1:0]       s_data,
  input  logic                        flush,
  input  logic                        hold,
  output logic                        we,
  output logic [ADDR_WIDTH-1:0]       Addr,
  output logic [DATA_WIDTH-1:0]       wr_data,
  output logic [$clog2(DEPTH):0]      count,
  output logic                        empty,
  output logic                        full
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [ADDR_WIDTH-1:0] addr_mem [DEPTH];
  logic [DATA_WIDTH-1:0] data_mem [DEPTH];
  logic [PW-1:0]         wr_ptr;
  logic [PW-1:0]         rd_ptr;
  logic                  push;

  // Handshake: a request transfers on a rising edge where s_valid and s_ready are
  // both 1. s_ready never looks at a same-cycle pop, so a full queue always refuses.
  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign s_ready = ~full & ~reset & ~flush;
  assign push    = s_valid & s_ready;
  assign we      = ~empty & ~hold & ~reset & ~flush;
  assign Addr    = addr_mem[rd_ptr];
  assign wr_data = data_mem[rd_ptr];

  // Storage is deliberately not cleared by reset or flush.
  always_ff @(posedge clk) begin
    if (push) begin
      addr_mem[wr_ptr] <= s_addr;
      data_mem[wr_ptr] <= s_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (we)   rd_ptr <= rd_ptr + PW'(1);
      case ({push, we})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_write_queue.sv
// Bench for write_queue: directed scenarios with literal expectations, then random traffic,
// all compared every cycle against a queue-based model of the request stream.
module tb_write_queue;
  localparam int DW    = 32;
  localparam int AW    = 3;
  localparam int DEPTH = 4;
  localparam int W     = AW + DW;

  logic          clk = 1'b0;
  logic          reset;
  logic          s_valid;
  logic          s_ready;
  logic [AW-1:0] s_addr;
  logic [DW-1:0] s_data;
  logic          flush;
  logic          hold;
  logic          we;
  logic [AW-1:0] Addr;
  logic [DW-1:0] wr_data;
  logic [$clog2(DEPTH):0] count;
  logic          empty;
  logic          full;

  write_queue #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .s_valid(s_valid), .s_ready(s_ready),
    .s_addr(s_addr), .s_data(s_data), .flush(flush), .hold(hold),
    .we(we), .Addr(Addr), .wr_data(wr_data), .count(count),
    .empty(empty), .full(full)
  );

  always #5 clk = ~clk;

  int check_cnt = 0;
  int pass_cnt  = 0;
  logic [W-1:0] exp_q[$];
  logic chk_en = 1'b0;
  logic model_push = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    check_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Model: a request queue; pop the head when draining is allowed, append accepted pushes.
  always @(posedge clk) begin
    bit do_pop, do_push;
    do_pop  = 1'b0;
    do_push = 1'b0;
    if (reset) chk_en = 1'b1;
    if (reset || flush) begin
      exp_q.delete();
    end else begin
      do_pop  = (exp_q.size() != 0) && !hold;
      do_push = s_valid && (exp_q.size() != DEPTH);
      if (do_pop) void'(exp_q.pop_front());
      if (do_push) exp_q.push_back({s_addr, s_data});
    end
    model_push = do_push;
  end

  always @(negedge clk) begin
    if (chk_en) begin
      bit exp_we;
      exp_we = (exp_q.size() != 0) && !hold && !reset && !flush;
      check("s_ready", 64'(s_ready), 64'((exp_q.size() != DEPTH) && !reset && !flush));
      check("we", 64'(we), 64'(exp_we));
      check("count", 64'(count), 64'(exp_q.size()));
      check("empty", 64'(empty), 64'(exp_q.size() == 0));
      check("full", 64'(full), 64'(exp_q.size() == DEPTH));
      if (exp_we) begin
        check("Addr", 64'(Addr), 64'(exp_q[0][W-1:DW]));
        check("wr_data", 64'(wr_data), 64'(exp_q[0][DW-1:0]));
      end
    end
  end

  task automatic push_one(input int a, input int d);
    s_valid = 1'b1;
    s_addr  = AW'(a);
    s_data  = DW'(d);
    tick();
    s_valid = 1'b0;
  endtask

  initial begin
    reset = 1'b1; s_valid = 1'b0; s_addr = '0; s_data = '0; flush = 1'b0; hold = 1'b0;
    tick(); tick();
    reset = 1'b0;
    @(negedge clk);
    check("post_reset_count", 64'(count), 64'd0);
    check("post_reset_ready", 64'(s_ready), 64'd1);
    tick();

    // Single push, drained the next cycle
    push_one(5, 32'hA5A5_0001);
    @(negedge clk);
    check("single_we", 64'(we), 64'd1);
    check("single_addr", 64'(Addr), 64'd5);
    check("single_data", 64'(wr_data), 64'hA5A5_0001);
    check("single_count", 64'(count), 64'd1);
    tick();
    @(negedge clk);
    check("single_empty", 64'(empty), 64'd1);
    check("single_we_after", 64'(we), 64'd0);
    tick();

    // Fill under hold, refuse a fifth, then drain in order
    hold = 1'b1;
    for (int i = 0; i < 4; i++) push_one(i, 100 + i);
    s_valid = 1'b1; s_addr = 3'd7; s_data = 32'hDEAD;
    @(negedge clk);
    check("hold_count", 64'(count), 64'd4);
    check("hold_full", 64'(full), 64'd1);
    check("hold_ready", 64'(s_ready), 64'd0);
    tick();
    s_valid = 1'b0;
    hold = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("drain_we", 64'(we), 64'd1);
      check("drain_addr", 64'(Addr), 64'(i));
      tick();
    end
    @(negedge clk);
    check("drain_empty", 64'(empty), 64'd1);
    tick();

    // Continuous push and pop across two pointer wraps
    for (int i = 0; i < 10; i++) begin
      s_valid = 1'b1; s_addr = AW'(i % 8); s_data = DW'(i);
      if (i > 0) begin
        @(negedge clk);
        check("stream_count", 64'(count), 64'd1);
        check("stream_addr", 64'(Addr), 64'((i - 1) % 8));
        check("stream_data", 64'(wr_data), 64'(i - 1));
      end
      tick();
    end
    s_valid = 1'b0;
    @(negedge clk);
    check("stream_last_data", 64'(wr_data), 64'd9);
    tick();

    // Full queue with a pending push: 4 -> 3 -> 3
    hold = 1'b1;
    for (int i = 0; i < 4; i++) push_one(i, 200 + i);
    hold = 1'b0;
    s_valid = 1'b1; s_addr = 3'd4; s_data = 32'd204;
    @(negedge clk);
    check("full_pop_count", 64'(count), 64'd4);
    check("full_pop_ready", 64'(s_ready), 64'd0);
    tick();
    @(negedge clk);
    check("full_pop_count2", 64'(count), 64'd3);
    tick();
    s_valid = 1'b0;
    @(negedge clk);
    check("full_pop_count3", 64'(count), 64'd3);
    for (int i = 0; i < 4; i++) tick();

    // Flush with three queued entries and a request waiting
    hold = 1'b1;
    for (int i = 0; i < 3; i++) push_one(i + 1, 300 + i);
    hold = 1'b0; flush = 1'b1; s_valid = 1'b1; s_addr = 3'd6; s_data = 32'd399;
    @(negedge clk);
    check("flush_we", 64'(we), 64'd0);
    check("flush_ready", 64'(s_ready), 64'd0);
    tick();
    flush = 1'b0; s_valid = 1'b0;
    @(negedge clk);
    check("flush_count", 64'(count), 64'd0);
    check("flush_empty", 64'(empty), 64'd1);
    tick(); tick();

    // Reset mid-drain with two entries pending
    hold = 1'b1;
    for (int i = 0; i < 3; i++) push_one(6 + (i % 2), 400 + i);
    hold = 1'b0;
    tick();
    reset = 1'b1;
    @(negedge clk);
    check("reset_we", 64'(we), 64'd0);
    tick();
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("reset_after_we", 64'(we), 64'd0);
      check("reset_after_count", 64'(count), 64'd0);
      tick();
    end

    // Random traffic; a refused request keeps its address and data stable
    for (int c = 0; c < 3000; c++) begin
      if (!s_valid || model_push) begin
        s_valid = ($urandom_range(0, 3) != 0);
        s_addr  = AW'($urandom_range(0, 7));
        s_data  = $urandom;
      end
      hold  = ($urandom_range(0, 3) == 0);
      flush = ($urandom_range(0, 60) == 0);
      reset = ($urandom_range(0, 150) == 0);
      tick();
    end
    s_valid = 1'b0; hold = 1'b0; flush = 1'b0; reset = 1'b0;
    for (int i = 0; i < 6; i++) tick();
    @(negedge clk);
    check("final_empty", 64'(empty), 64'd1);

    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end
endmodule

// File: doc/write_queue.md
# write_queue

Buffered write-request stage that sits directly upstream of the 3-to-8 write-enable decoder stage feeding the 8-entry register file. It accepts register write requests (address plus data) over a valid/ready handshake, holds up to DEPTH of them in a FIFO, and drains one per cycle as the `we`/`Addr` pair the decoder consumes, plus the matching write data for the register file. A downstream `hold` input stalls draining without losing requests.

## Interface

Parameters:

- DATA_WIDTH, 32, width of the register write data.
- ADDR_WIDTH, 3, register address width; matches the decoder's 3-bit `Addr`.
- DEPTH, 4, FIFO entries; must be a power of 2 and at least 2.

Ports:

- clk, in, 1, single clock; all state updates on the rising edge.
- reset, in, 1, synchronous active-high reset.
- s_valid, in, 1, upstream write request present.
- s_ready, out, 1, queue can accept a request this cycle.
- s_addr, in, ADDR_WIDTH, register address of the request.
- s_data, in, DATA_WIDTH, write data of the request.
- flush, in, 1, synchronous discard of all queued entries.
- hold, in, 1, downstream stall; blocks draining.
- we, out, 1, write enable to the decoder stage.
- Addr, out, ADDR_WIDTH, register address to the decoder stage.
- wr_data, out, DATA_WIDTH, data for the register selected by the decoder.
- count, out, log2(DEPTH)+1, number of valid entries.
- empty, out, 1, count == 0.
- full, out, 1, count == DEPTH.

## Operation

- Storage: circular buffer of {addr, data} with wr_ptr and rd_ptr, each log2(DEPTH) bits, wrapping modulo DEPTH. `count` is a separate register.
- Push:
  - `push = s_valid & s_ready`.
  - `s_ready = ~full & ~reset & ~flush`.
  - On push, the entry is written at wr_ptr and wr_ptr increments.
  - `s_ready` does not depend on a same-cycle pop, so a full queue refuses a push even while draining.
- Pop:
  - `we = ~empty & ~hold & ~reset & ~flush`.
  - `Addr` and `wr_data` are driven combinationally from the head entry.
  - When `we`=1 the register file captures the write at that clock edge, and rd_ptr increments on the same edge.
  - When `we`=0, `Addr` and `wr_data` show the head entry, or stale storage if empty. They are don't-care for consumers.
- Count update:
  - Push only: +1.
  - Pop only: −1.
  - Push and pop together: unchanged, with both pointers advancing.
  - Neither: unchanged.
- Ordering: strict FIFO. Writes to the same address are never merged or reordered.
- `flush`: pointers and count go to 0 at the next edge. In the flush cycle, `s_ready`=0 and `we`=0, so no push or pop occurs.
- `reset`: same effect as `flush`, and has priority over it. Storage contents are not cleared.
- `hold` while empty has no effect. `hold` never affects `s_ready`.
- `s_valid` with `s_ready`=0: the request is not taken. Upstream must keep `s_addr`/`s_data` stable until accepted.

## Timing

- Reset values, in the reset cycle and the first cycle after it:
  - we=0, count=0, empty=1, full=0.
  - wr_ptr=rd_ptr=0.
  - s_ready=0 during reset and 1 afterwards.
- Latency: a request pushed at edge N is drained (`we`=1, matching `Addr`/`wr_data`) in the cycle after edge N at the earliest. There is no same-cycle bypass when empty.
- Throughput: one push and one pop per cycle sustained, provided the queue is neither full nor empty.
- `full` and `empty` are derived from the registered `count` and are stable for the whole cycle.
- Pointer wrap: after DEPTH pushes, wr_ptr returns to 0. Contents and order must be preserved across the wrap.
- Reset or flush mid-burst: all pending entries are lost. No `we` pulse may appear in the reset/flush cycle.

## Test plan

- Reset, then one push of {addr=5, data=0xA5A5_0001} -> next cycle we=1, Addr=5, wr_data=0xA5A5_0001, count=1; after the pop edge, empty=1 and we=0.
- Push addrs 0,1,2,3 with hold=1 -> count=4, full=1, s_ready=0; a fifth s_valid is not accepted; release hold -> 4 consecutive we pulses, Addr 0,1,2,3 in order.
- Continuous push and pop for 10 requests (addr=i mod 8, data=i) -> count stays at 1 after the first push; outputs match in order across two pointer wraps.
- Full queue with hold=0 and s_valid=1 -> no push in the full cycle, one pop; the push lands the next cycle; count goes 4 -> 3 -> 3.
- Three entries queued, assert flush for one cycle with s_valid=1 -> we=0 and s_ready=0 that cycle; afterwards count=0, empty=1, and no we pulses.
- Reset asserted mid-drain with 2 entries pending -> we=0 in the reset cycle; afterwards count=0, and the old entries never appear on Addr/we.
